spad_seq_ctrl: RTL and testbench



---
 rtl/spad_seq_ctrl_if.sv | 21 ++
 rtl/spad_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_spad_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spad_seq_ctrl_if.sv
// Feature-fetch stream between the fetch unit and the scratchpad sequencer.
// master: drives fetch_data/fetch_valid; slave: returns fetch_ready.
interface spad_seq_ctrl_if #(
  parameter int DATA_BUS_WIDTH = 128
);
  logic [DATA_BUS_WIDTH-1:0] fetch_data;
  logic                      fetch_valid;
  logic                      fetch_ready;

  modport master (
    output fetch_data,
    output fetch_valid,
    input  fetch_ready
  );

  modport slave (
    input  fetch_data,
    input  fetch_valid,
    output fetch_ready
  );
endinterface

// File: rtl/spad_seq_ctrl.sv
// Scratchpad sequencer: primes K lines, streams rows, refills line K-1.
// Ports: clk/rst, start+cfg, fetch (if slave), spad wr/rd, win_*, busy/done.
// Optional SPAD_SEQ_PERF_EN adds stall_cycles (empty-stall counter).
module spad_seq_ctrl #(
  parameter int KERNEL_SIZE    = 5,
  parameter int FEATURE_WIDTH  = 16,
  parameter int DATA_BUS_WIDTH = 128,
  parameter int BEATS_W        = 8,
  parameter int ROWS_W         = 10,
  parameter int FLUSH_CYC      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BEATS_W-1:0]        cfg_row_beats,
  input  logic [ROWS_W-1:0]         cfg_out_rows,
  spad_seq_ctrl_if.slave            fetch,
  output logic [3:0]                spad_wr_mem_line,
  output logic                      spad_wr_en,
  output logic [DATA_BUS_WIDTH-1:0] spad_data,
  output logic                      spad_rd_en,
  input  logic                      spad_group_empty,
  input  logic                      spad_group_full,
  output logic                      win_valid,
  output logic                      win_last,
`ifdef SPAD_SEQ_PERF_EN
  output logic [31:0]               stall_cycles,
`endif
  output logic                      busy,
  output logic                      done
);

  localparam int FPB   = DATA_BUS_WIDTH / FEATURE_WIDTH;
  localparam int COL_W = BEATS_W + $clog2(FPB);
  localparam int CNT_W = $clog2(FLUSH_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [3:0] LAST_LINE = 4'(KERNEL_SIZE - 1);

  logic [2:0]         state_q, state_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic [ROWS_W-1:0]  rows_q, rows_d;
  logic [3:0]         line_q, line_d;
  logic [BEATS_W-1:0] beat_q, beat_d;
  logic [BEATS_W-1:0] rbeat_q, rbeat_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROWS_W-1:0]  orow_q, orow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wv_q, wv_d;
  logic               wl_q, wl_d;

  logic [COL_W-1:0] row_len;
  logic             last_beat;
  logic             last_row;
  logic             refill_done;
  logic             refill_act;
  logic             col_lt;
  logic             rd_en;
  logic             ready;
  logic             xfer;
  logic             flush_ok;
  logic             in_run;

  assign row_len     = COL_W'(beats_q) * COL_W'(FPB);
  assign last_beat   = beat_q == beats_q - BEATS_W'(1);
  assign last_row    = orow_q == rows_q - ROWS_W'(1);
  assign refill_done = rbeat_q == beats_q;
  assign in_run      = (state_q == S_STREAM) | (state_q == S_FLUSH);
  // Refill feeds the next input row; the final output row needs none.
  assign refill_act  = in_run & ~last_row & ~refill_done;
  assign col_lt      = col_q < row_len;
  assign rd_en       = (state_q == S_STREAM) & col_lt & ~spad_group_empty;
  // Never a function of fetch_valid: keeps the handshake loop-free.
  assign ready       = (state_q == S_PRIME) | (refill_act & ~spad_group_full);
  assign xfer        = fetch.fetch_valid & ready;
  assign flush_ok    = cnt_q >= CNT_W'(FLUSH_CYC - 1);

  assign fetch.fetch_ready = ready;
  assign spad_wr_en        = xfer;
  assign spad_data         = fetch.fetch_data;
  assign spad_rd_en        = rd_en;
  assign win_valid         = wv_q;
  assign win_last          = wl_q;
  assign busy              = state_q != S_IDLE;
  assign done              = state_q == S_FIN;

  always_comb begin
    spad_wr_mem_line = 4'd0;
    if (state_q == S_PRIME) begin
      spad_wr_mem_line = line_q;
    end else if (in_run) begin
      spad_wr_mem_line = LAST_LINE;
    end
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    rows_d  = rows_q;
    line_d  = line_q;
    beat_d  = beat_q;
    rbeat_d = rbeat_q;
    col_d   = col_q;
    orow_d  = orow_q;
    cnt_d   = cnt_q;
    wv_d    = rd_en;
    wl_d    = rd_en & (col_q == row_len - COL_W'(1));

    if (in_run && xfer) begin
      rbeat_d = rbeat_q + BEATS_W'(1);
    end

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          beats_d = cfg_row_beats;
          rows_d  = cfg_out_rows;
          line_d  = 4'd0;
          beat_d  = '0;
          if (cfg_row_beats == '0 || cfg_out_rows == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_PRIME;
          end
        end
      end
      state_q == S_PRIME: begin
        if (xfer) begin
          if (last_beat) begin
            beat_d = '0;
            if (line_q == LAST_LINE) begin
              state_d = S_STREAM;
              orow_d  = '0;
              col_d   = '0;
              rbeat_d = '0;
            end else begin
              line_d = line_q + 4'd1;
            end
          end else begin
            beat_d = beat_q + BEATS_W'(1);
          end
        end
      end
      state_q == S_STREAM: begin
        if (rd_en) begin
          col_d = col_q + COL_W'(1);
          if (col_q == row_len - COL_W'(1)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
        end
      end
      state_q == S_FLUSH: begin
        if (!flush_ok) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (refill_done || last_row) begin
          orow_d  = orow_q + ROWS_W'(1);
          col_d   = '0;
          rbeat_d = '0;
          state_d = last_row ? S_FIN : S_STREAM;
        end
      end
      state_q == S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      rows_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      rbeat_q <= '0;
      col_q   <= '0;
      orow_q  <= '0;
      cnt_q   <= '0;
      wv_q    <= 1'b0;
      wl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      rows_q  <= rows_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      rbeat_q <= rbeat_d;
      col_q   <= col_d;
      orow_q  <= orow_d;
      cnt_q   <= cnt_d;
      wv_q    <= wv_d;
      wl_q    <= wl_d;
    end
  end

`ifdef SPAD_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_STREAM && col_lt && spad_group_empty
                 && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_spad_seq_ctrl.sv
// Self-checking bench for spad_seq_ctrl.
// Transaction-level model: expected write lines, read/window counts, done.
module tb_spad_seq_ctrl;
  localparam int K   = 5;
  localparam int DBW = 128;
  localparam int BW  = 8;
  localparam int RW  = 10;
  localparam int FC  = 4;
  localparam int FPB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [BW-1:0]  cfg_row_beats;
  logic [RW-1:0]  cfg_out_rows;
  logic [3:0]     spad_wr_mem_line;
  logic           spad_wr_en;
  logic [DBW-1:0] spad_data;
  logic           spad_rd_en;
  logic           spad_group_empty;
  logic           spad_group_full;
  logic           win_valid;
  logic           win_last;
  logic           busy;
  logic           done;
`ifdef SPAD_SEQ_PERF_EN
  logic [31:0]    stall_cycles;
`endif

  spad_seq_ctrl_if #(.DATA_BUS_WIDTH(DBW)) fif ();

  spad_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_row_beats    (cfg_row_beats),
    .cfg_out_rows     (cfg_out_rows),
    .fetch            (fif.slave),
    .spad_wr_mem_line (spad_wr_mem_line),
    .spad_wr_en       (spad_wr_en),
    .spad_data        (spad_data),
    .spad_rd_en       (spad_rd_en),
    .spad_group_empty (spad_group_empty),
    .spad_group_full  (spad_group_full),
    .win_valid        (win_valid),
    .win_last         (win_last),
`ifdef SPAD_SEQ_PERF_EN
    .stall_cycles     (stall_cycles),
`endif
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  int vmode = 0;
  int fmode = 0;
  int tog   = 0;

  int cyc = 0;
  int wr_q[$];
  int n_rd, n_wv, n_wl, bad_last, n_done, n_ready;
  int rd_empty, empty_idle, data_bad;
  int min_gap, last_rd, first_rd, first_wr, prime_cyc, row0_end;
  int cur_len = 8;
  int prime_n = 5;

  always @(posedge clk) begin
    #1;
    case (vmode)
      0: fif.fetch_valid = 1'b1;
      1: begin
        fif.fetch_valid = tog[0];
        tog = tog + 1;
      end
      default: fif.fetch_valid = $urandom_range(0, 1) == 1;
    endcase
    fif.fetch_data = {$urandom, $urandom, $urandom, $urandom};
    spad_group_full = (fmode != 0) && ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (spad_wr_en) begin
      if (wr_q.size() == 0) first_wr = cyc;
      wr_q.push_back(int'(spad_wr_mem_line));
      if (wr_q.size() == prime_n) prime_cyc = cyc;
      if (spad_data !== fif.fetch_data) data_bad++;
    end
    if (fif.fetch_ready) n_ready++;
    if (spad_group_empty && !spad_rd_en) empty_idle++;
    if (spad_rd_en) begin
      if (n_rd == 0) first_rd = cyc;
      if (n_rd > 0 && n_rd % cur_len == 0 && cyc - last_rd < min_gap)
        min_gap = cyc - last_rd;
      last_rd = cyc;
      n_rd++;
      if (n_rd == cur_len) row0_end = cyc;
      if (spad_group_empty) rd_empty++;
    end
    if (win_valid) begin
      n_wv++;
      if (win_last) n_wl++;
      if (win_last != (n_wv % cur_len == 0)) bad_last++;
    end else if (win_last) begin
      bad_last++;
    end
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int beats);
    wr_q.delete();
    n_rd = 0; n_wv = 0; n_wl = 0; bad_last = 0; n_done = 0;
    n_ready = 0; rd_empty = 0; empty_idle = 0; data_bad = 0;
    min_gap = 1000; last_rd = 0; first_rd = 0; first_wr = 0;
    prime_cyc = 0; row0_end = 0;
    cur_len = (beats == 0) ? 8 : beats * FPB;
    prime_n = K * beats;
  endtask

  task automatic start_job(input int beats, input int rows);
    clear_mon(beats);
    @(posedge clk); #1;
    cfg_row_beats = BW'(beats);
    cfg_out_rows  = RW'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (n_done == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, t < 5000, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic finish_job(input string tag, input int beats,
                            input int rows);
    int exp_q[$];
    int bad = 0;
    int nrd;
    for (int l = 0; l < K; l++)
      for (int b = 0; b < beats; b++) exp_q.push_back(l);
    for (int r = 1; r < rows; r++)
      for (int b = 0; b < beats; b++) exp_q.push_back(K - 1);
    nrd = rows * beats * FPB;
    foreach (exp_q[i])
      if (i < wr_q.size() && wr_q[i] != exp_q[i]) bad++;
    chk({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    chk({tag, "_wr_lines"}, bad, 0);
    chk({tag, "_wr_data"}, data_bad, 0);
    chk({tag, "_rd_count"}, n_rd, nrd);
    chk({tag, "_wv_count"}, n_wv, nrd);
    chk({tag, "_wl_count"}, n_wl, rows);
    chk({tag, "_wl_pos"}, bad_last, 0);
    chk({tag, "_done_once"}, n_done, 1);
    chk({tag, "_flush_gap"}, min_gap >= FC + 1, 1);
    chk({tag, "_rd_after_prime"}, first_rd > prime_cyc, 1);
    if (vmode == 0)
      chk({tag, "_prime_b2b"}, prime_cyc - first_wr, prime_n - 1);
  endtask

  task automatic run_job(input string tag, input int beats,
                         input int rows, input bit poke);
    start_job(beats, rows);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      cfg_row_beats = 8'd4;
      cfg_out_rows  = 10'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(tag);
    finish_job(tag, beats, rows);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    cfg_row_beats = '0;
    cfg_out_rows = '0;
    spad_group_empty = 1'b0;
    spad_group_full = 1'b0;
    fif.fetch_valid = 1'b0;
    fif.fetch_data = '0;
    #2;
    chk("reset_outs",
        {fif.fetch_ready, spad_wr_en, spad_rd_en, win_valid,
         win_last, busy, done}, 0);
    chk("reset_line", spad_wr_mem_line, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    vmode = 0;
    run_job("k1r1", 1, 1, 1'b0);
    run_job("b2r3", 2, 3, 1'b1);

    vmode = 1;
    run_job("toggle", 3, 2, 1'b0);

    vmode = 0;
    start_job(2, 2);
    t = 0;
    while (n_rd < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach", t < 2000, 1);
    @(posedge clk); #1;
    spad_group_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1 spad_group_empty = 1'b0;
    wait_done("stall");
    finish_job("stall", 2, 2);
    chk("stall_no_rd", rd_empty, 0);
    chk("stall_idle_cyc", empty_idle, 3);
    chk("stall_row0_span", row0_end - first_rd + 1, 16 + 3);
`ifdef SPAD_SEQ_PERF_EN
    chk("stall_cycles", stall_cycles, 3);
`endif

    for (int z = 0; z < 2; z++) begin
      clear_mon(0);
      @(posedge clk); #1;
      cfg_row_beats = (z == 0) ? 8'd0 : 8'd2;
      cfg_out_rows  = (z == 0) ? 10'd3 : 10'd0;
      start = 1'b1;
      @(posedge clk); #1;
      cfg_row_beats = 8'd2;
      cfg_out_rows  = 10'd2;
      @(negedge clk);
      chk("zero_done_now", done, 1);
      chk("zero_busy_fin", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("zero_idle", {busy, done}, 0);
      repeat (5) @(negedge clk);
      chk("zero_ready", n_ready, 0);
      chk("zero_rd", n_rd, 0);
      chk("zero_done_cnt", n_done, 1);
    end

    start_job(3, 2);
    t = 0;
    while (n_rd < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach", t < 2000, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs",
        {fif.fetch_ready, spad_wr_en, spad_rd_en, win_valid,
         win_last, busy, done}, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_done", n_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_job("after_rst", 2, 2, 1'b0);

    vmode = 2;
    fmode = 1;
    for (int j = 0; j < 6; j++) begin
      int b = $urandom_range(1, 4);
      int r = $urandom_range(1, 4);
      run_job($sformatf("rnd%0d", j), b, r, j[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end
endmodule
